// File: rtl/psc_trigger_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : psc_trigger_frame_sequencer
// Purpose  : Chooses and streams power-supply-controller frames from an
//            external frame ROM to a byte-wide serial transmitter.
//            A trigger frame is sent on request; a heartbeat frame is sent
//            after HB_PERIOD idle clocks. Bytes are handed over with a
//            valid/ready handshake at up to one byte per clock, and the
//            SOP/EOP positions are flagged as K-characters.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   FRAME_LEN        bytes per frame, ROM addresses 0..FRAME_LEN-1 (<= 15)
//   HB_PERIOD        idle clocks before a heartbeat becomes pending (>= 2)
//   GAP_CYCLES       idle clocks between end of a frame and next IDLE (>= 1)
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   enable           1 = frames may start; 0 = finish current frame, then idle
//   trigger_req      single-cycle trigger-frame request
//   rom_address      frame ROM address
//   rom_is_trigger   frame ROM type select (1 = trigger, 0 = heartbeat)
//   rom_data         combinational ROM data for rom_address
//   tx_data/tx_k     byte to transmitter and its K-character flag
//   tx_valid         tx_data/tx_k valid
//   tx_ready         transmitter accepts when tx_valid && tx_ready
//   busy             1 while sending a frame or in the inter-frame gap
//   trigger_ack      one-clock pulse when a trigger frame's last byte is taken
//   frames_sent      completed frame count, wraps
//   dropped_triggers merged trigger request count, saturates at 255
// ============================================================================
module psc_trigger_frame_sequencer #(
  parameter int unsigned FRAME_LEN  = 11,
  parameter int unsigned HB_PERIOD  = 50000,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        trigger_req,
  output logic [3:0]  rom_address,
  output logic        rom_is_trigger,
  input  logic [7:0]  rom_data,
  output logic [7:0]  tx_data,
  output logic        tx_k,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        trigger_ack,
  output logic [15:0] frames_sent,
  output logic [7:0]  dropped_triggers
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int unsigned HB_W  = (HB_PERIOD  > 1) ? $clog2(HB_PERIOD)  : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // The frame index runs one past the last byte so that "index == FRAME_LEN"
  // means every byte has been loaded and the last one sits in tx_data.
  localparam logic [3:0]       C_LAST_IDX = 4'(FRAME_LEN);
  localparam logic [3:0]       C_EOP_IDX  = 4'(FRAME_LEN - 2);
  localparam logic [HB_W-1:0]  C_HB_TOP   = HB_W'(HB_PERIOD - 1);
  localparam logic [GAP_W-1:0] C_GAP_TOP  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t             state_q;
  logic [3:0]         idx_q;
  logic               rom_is_trigger_q;
  logic [7:0]         tx_data_q;
  logic               tx_k_q;
  logic               tx_valid_q;
  logic               trigger_ack_q;
  logic [15:0]        frames_sent_q;
  logic [GAP_W-1:0]   gap_cnt_q;

  // Pending flags and counters with separately computed next state
  logic               trig_pend_q;
  logic               trig_pend_d;
  logic [7:0]         dropped_q;
  logic [7:0]         dropped_d;
  logic               hb_pend_q;
  logic               hb_pend_d;
  logic [HB_W-1:0]    hb_cnt_q;
  logic [HB_W-1:0]    hb_cnt_d;

  // --------------------------------------------------------------------------
  // Control decodes
  // --------------------------------------------------------------------------
  logic               w_start;
  logic               w_load;
  logic               w_last_accept;
  logic               w_req;
  logic [HB_W-1:0]    w_hb_inc;

  assign w_req    = trigger_req && enable;
  assign w_start  = (state_q == S_IDLE) && enable && (trig_pend_q || hb_pend_q);
  // Prefetch: a new byte is loaded whenever the output register is empty or
  // is being emptied this clock, which sustains one byte per clock.
  assign w_load   = (state_q == S_SEND) && (!tx_valid_q || tx_ready) &&
                    (idx_q < C_LAST_IDX);
  assign w_last_accept = (state_q == S_SEND) && tx_valid_q && tx_ready &&
                         (idx_q == C_LAST_IDX);
  assign w_hb_inc = hb_cnt_q + HB_W'(1);

  // --------------------------------------------------------------------------
  // Trigger pending flag and dropped-request counter
  // --------------------------------------------------------------------------
  // A request arriving while a trigger is already pending is merged into it
  // and counted. A request that coincides with a heartbeat departure finds
  // the flag clear, so it is latched and served after the gap.
  always_comb begin
    trig_pend_d = trig_pend_q;
    dropped_d   = dropped_q;
    if (w_start) begin
      trig_pend_d = 1'b0;
    end
    if (w_req) begin
      if (trig_pend_q) begin
        if (dropped_q != 8'hFF) begin
          dropped_d = dropped_q + 8'd1;
        end
      end else begin
        trig_pend_d = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Heartbeat idle counter
  // --------------------------------------------------------------------------
  // Counts only while idle and enabled; the pending flag is raised on the
  // clock the count reaches HB_PERIOD-1. Any frame start (trigger or
  // heartbeat) restarts the idle interval.
  always_comb begin
    hb_cnt_d  = hb_cnt_q;
    hb_pend_d = hb_pend_q;
    if (w_start) begin
      hb_cnt_d  = '0;
      hb_pend_d = 1'b0;
    end else if ((state_q == S_IDLE) && enable) begin
      if (hb_cnt_q != C_HB_TOP) begin
        hb_cnt_d = w_hb_inc;
        if (w_hb_inc == C_HB_TOP) begin
          hb_pend_d = 1'b1;
        end
      end
    end else begin
      hb_cnt_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      idx_q            <= 4'd0;
      rom_is_trigger_q <= 1'b0;
      tx_data_q        <= 8'd0;
      tx_k_q           <= 1'b0;
      tx_valid_q       <= 1'b0;
      trigger_ack_q    <= 1'b0;
      frames_sent_q    <= 16'd0;
      gap_cnt_q        <= '0;
      trig_pend_q      <= 1'b0;
      dropped_q        <= 8'd0;
      hb_pend_q        <= 1'b0;
      hb_cnt_q         <= '0;
    end else begin
      trig_pend_q   <= trig_pend_d;
      dropped_q     <= dropped_d;
      hb_pend_q     <= hb_pend_d;
      hb_cnt_q      <= hb_cnt_d;
      trigger_ack_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (w_start) begin
            state_q          <= S_SEND;
            // Trigger wins when both are pending; it also serves as heartbeat.
            rom_is_trigger_q <= trig_pend_q;
            idx_q            <= 4'd0;
          end
        end

        S_SEND: begin
          if (w_load) begin
            tx_data_q  <= rom_data;
            tx_k_q     <= (idx_q == 4'd0) || (idx_q >= C_EOP_IDX);
            tx_valid_q <= 1'b1;
            idx_q      <= idx_q + 4'd1;
          end else if (w_last_accept) begin
            tx_valid_q    <= 1'b0;
            frames_sent_q <= frames_sent_q + 16'd1;
            trigger_ack_q <= rom_is_trigger_q;
            gap_cnt_q     <= '0;
            state_q       <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt_q == C_GAP_TOP) begin
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end

        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rom_address      = idx_q;
  assign rom_is_trigger   = rom_is_trigger_q;
  assign tx_data          = tx_data_q;
  assign tx_k             = tx_k_q;
  assign tx_valid         = tx_valid_q;
  assign busy             = (state_q != S_IDLE);
  assign trigger_ack      = trigger_ack_q;
  assign frames_sent      = frames_sent_q;
  assign dropped_triggers = dropped_q;

endmodule
`default_nettype wire

// File: doc/psc_trigger_frame_sequencer.md
Name: psc_trigger_frame_sequencer

Overview:
Sequences the 11-byte power-supply-controller frame ROM onto the serial transmitter. It decides which frame to send: a trigger frame (is_trigger=1) on request, or a heartbeat frame (is_trigger=0) when the link has been idle. It walks the ROM address, streams each byte to the transmitter with a valid/ready handshake, and flags K-characters.

Parameters:
FRAME_LEN, 11, bytes per frame (ROM addresses 0..FRAME_LEN-1)
HB_PERIOD, 50000, idle clocks before a heartbeat frame becomes pending
GAP_CYCLES, 4, minimum idle clocks between end of one frame and start of next (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
enable  in  1  1 = frames may start; 0 = finish current frame, then stay idle
trigger_req  in  1  single-cycle request for a trigger frame
rom_address  out  4  address to frame ROM
rom_is_trigger  out  1  frame-type select to frame ROM
rom_data  in  8  combinational ROM data for rom_address
tx_data  out  8  byte to transmitter
tx_k  out  1  1 = tx_data is a K-character (SOP/EOP)
tx_valid  out  1  tx_data/tx_k valid
tx_ready  in  1  transmitter accepts byte when tx_valid&&tx_ready
busy  out  1  1 in SEND or GAP
trigger_ack  out  1  1-cycle pulse when the last byte of a trigger frame is accepted
frames_sent  out  16  count of completed frames, wraps
dropped_triggers  out  8  count of merged trigger requests, saturates at 255

Behaviour:
- Reset is asynchronous and active-low on rst_n, single clock clk. All outputs, counters and pending flags clear to 0 immediately. State = IDLE.
- A frame in progress when reset asserts is aborted; there is no resumption after release.
- Pending flags:
  - trigger_pend is set by trigger_req while enable=1; trigger_req is ignored while enable=0.
  - trigger_req while trigger_pend=1 increments dropped_triggers (saturating); the flag stays 1.
  - trigger_req during SEND/GAP with trigger_pend=0 queues the request normally.
- Heartbeat counter:
  - Counts clocks in IDLE while enable=1; held at 0 otherwise.
  - On reaching HB_PERIOD-1, hb_pend is set.
- States IDLE -> SEND -> GAP -> IDLE.
- IDLE:
  - If enable and (trigger_pend or hb_pend), go to SEND.
  - Trigger has priority: rom_is_trigger <= trigger_pend.
  - Both flags and the heartbeat counter clear on this transition; a trigger frame also serves as the heartbeat.
  - rom_address <= 0.
- SEND, prefetch streaming:
  - The internal index runs 0..FRAME_LEN. When (!tx_valid || tx_ready) and index<FRAME_LEN: tx_data <= rom_data, tx_k <= (index==0 || index>=FRAME_LEN-2), tx_valid <= 1, index/rom_address increment.
  - When (tx_valid && tx_ready) and index==FRAME_LEN: tx_valid <= 0.
  - Sustains 1 byte/clock while tx_ready=1.
  - tx_data and tx_k hold stable while tx_valid && !tx_ready.
  - rom_is_trigger is constant for the whole frame.
- Last-byte acceptance (byte FRAME_LEN-1): frames_sent increments; trigger_ack pulses if it was a trigger frame; go to GAP.
- GAP: count GAP_CYCLES clocks with tx_valid=0, then go to IDLE. Pending flags may be set during GAP.
- Latency: trigger_req high at edge N (IDLE) -> SEND at N+1 -> tx_valid=1 with SOP after edge N+2.
- enable falling mid-frame: the frame completes fully; no new frame starts until enable=1.
- Simultaneous trigger_req and IDLE->SEND departure on a heartbeat: the request is latched as pending and sent after the gap. It is not counted as dropped.

Test Plan:
- Reset release with enable=1, tx_ready=1, trigger_req pulse -> tx_valid after 2 edges. Bytes 0x3C,0x01,0x30,0x00x6,0xBC,0xBC on 11 consecutive clocks. tx_k=1 on bytes 0, 9, 10. trigger_ack pulses with byte 10. frames_sent=1.
- No triggers, HB_PERIOD=20 -> heartbeat frame with byte 2 = 0x00, trigger_ack stays 0. Frames repeat every 20+11+GAP_CYCLES+overhead clocks.
- tx_ready toggled pseudo-randomly -> tx_data/tx_k stable while stalled. Exactly 11 accepted bytes, correct order, no duplicates.
- Two trigger_req pulses while trigger_pend=1 -> dropped_triggers=2, one trigger frame. 300 extra pulses -> dropped_triggers saturates at 255.
- trigger_req during frame 1 -> second trigger frame starts exactly GAP_CYCLES+1 clocks after frame 1's last acceptance.
- rst_n asserted at byte 5 -> tx_valid=0 and counters=0 immediately. After release, nothing is sent until a new request arrives.
